ps2_note_decoder: RTL and testbench

- Upstream of the game controller: turns a PS/2 keyboard into the 7-bit `keyboard_note` the controller scores against `song_note`.
- Receives PS/2 set-2 frames, tracks make/break codes and maps a one-octave piano layout of keys to note numbers.
- Outputs 0 when no mapped key is held. Never outputs 7'h7F, which is reserved for song-finish.

---
 rtl/ps2_note_decoder_if.sv | 20 ++
 rtl/ps2_note_decoder.sv | 167 ++++++++++++++++
 tb/tb_ps2_note_decoder.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_note_decoder_if.sv
// PS/2 line inputs and decoded note/scan outputs for ps2_note_decoder.
// The decoder is the slave; whatever drives the PS/2 wires is the master.
interface ps2_note_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [6:0] keyboard_note;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  keyboard_note, scan_code, scan_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output keyboard_note, scan_code, scan_valid, frame_err
  );
endinterface

// File: rtl/ps2_note_decoder.sv
// PS/2 set-2 receiver and make/break decoder mapping one piano octave
// of keys onto 7-bit note numbers.
module ps2_note_decoder #(
  parameter logic [6:0]  BASE_NOTE      = 7'd60,
  parameter logic [16:0] TIMEOUT_CYCLES = 17'd100_000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  ps2_note_decoder_if.slave bus
);

  typedef enum logic {RX_IDLE, RX_SHIFT} rx_e;
  typedef enum logic [1:0] {D_IDLE, D_E0, D_F0, D_E0F0} dec_e;

  localparam logic [16:0] TMO_MAX = TIMEOUT_CYCLES - 17'd1;

  logic        clk_s1_q, clk_s2_q, clk_prev_q;
  logic        dat_s1_q, dat_s2_q;
  rx_e         rx_q, rx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [10:0] sh_q, sh_d;
  logic [16:0] tmo_q, tmo_d;
  dec_e        dec_q, dec_d;
  logic [7:0]  held_q, held_d;
  logic [6:0]  note_q, note_d;
  logic [7:0]  code_q, code_d;
  logic        sv_q, sv_d;
  logic        fe_q, fe_d;

  logic        fall;
  logic        done;
  logic        ok;
  logic [7:0]  rx_byte;
  logic [4:0]  km;

  // {hit, offset} for the one-octave layout
  function automatic logic [4:0] key_map(input logic [7:0] c);
    case (c)
      8'h1C:   key_map = {1'b1, 4'd0};
      8'h1D:   key_map = {1'b1, 4'd1};
      8'h1B:   key_map = {1'b1, 4'd2};
      8'h24:   key_map = {1'b1, 4'd3};
      8'h23:   key_map = {1'b1, 4'd4};
      8'h2B:   key_map = {1'b1, 4'd5};
      8'h2C:   key_map = {1'b1, 4'd6};
      8'h34:   key_map = {1'b1, 4'd7};
      8'h35:   key_map = {1'b1, 4'd8};
      8'h33:   key_map = {1'b1, 4'd9};
      8'h3C:   key_map = {1'b1, 4'd10};
      8'h3B:   key_map = {1'b1, 4'd11};
      8'h42:   key_map = {1'b1, 4'd12};
      default: key_map = 5'd0;
    endcase
  endfunction

  assign fall = clk_prev_q & ~clk_s2_q;

  always_comb begin
    rx_d  = rx_q;
    cnt_d = cnt_q;
    sh_d  = sh_q;
    tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 17'd1;
    done  = 1'b0;
    if (fall) begin
      tmo_d = 17'd0;
      sh_d  = {dat_s2_q, sh_q[10:1]};
      if (cnt_q == 4'd10) begin
        done  = 1'b1;
        cnt_d = 4'd0;
        rx_d  = RX_IDLE;
      end else begin
        cnt_d = cnt_q + 4'd1;
        rx_d  = RX_SHIFT;
      end
    end else if (rx_q == RX_SHIFT && tmo_q == TMO_MAX) begin
      cnt_d = 4'd0;
      rx_d  = RX_IDLE;
    end
  end

  assign rx_byte = sh_d[8:1];
  assign ok = ~sh_d[0] & sh_d[10] & (^sh_d[9:1]);
  assign km = key_map(rx_byte);

  always_comb begin
    dec_d  = dec_q;
    held_d = held_q;
    note_d = note_q;
    code_d = code_q;
    sv_d   = 1'b0;
    fe_d   = 1'b0;
    if (done && !ok) begin
      fe_d = 1'b1;
    end else if (done) begin
      sv_d   = 1'b1;
      code_d = rx_byte;
      unique case (dec_q)
        D_IDLE: begin
          if (rx_byte == 8'hE0) begin
            dec_d = D_E0;
          end else if (rx_byte == 8'hF0) begin
            dec_d = D_F0;
          end else if (km[4]) begin
            held_d = rx_byte;
            note_d = BASE_NOTE + {3'b000, km[3:0]};
          end
        end
        D_E0: begin
          dec_d = (rx_byte == 8'hF0) ? D_E0F0 : D_IDLE;
        end
        D_E0F0: begin
          dec_d = D_IDLE;
        end
        D_F0: begin
          dec_d = D_IDLE;
          if (rx_byte == held_q) begin
            held_d = 8'd0;
            note_d = 7'd0;
          end
        end
        default: dec_d = D_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      rx_q       <= RX_IDLE;
      cnt_q      <= 4'd0;
      sh_q       <= 11'd0;
      tmo_q      <= 17'd0;
      dec_q      <= D_IDLE;
      held_q     <= 8'd0;
      note_q     <= 7'd0;
      code_q     <= 8'd0;
      sv_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      clk_s1_q   <= bus.ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= bus.ps2_data;
      dat_s2_q   <= dat_s1_q;
      rx_q       <= rx_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      tmo_q      <= tmo_d;
      dec_q      <= dec_d;
      held_q     <= held_d;
      note_q     <= note_d;
      code_q     <= code_d;
      sv_q       <= sv_d;
      fe_q       <= fe_d;
    end
  end

  assign bus.keyboard_note = note_q;
  assign bus.scan_code     = code_q;
  assign bus.scan_valid    = sv_q;
  assign bus.frame_err     = fe_q;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Bench for ps2_note_decoder: directed scenarios plus random key events
// checked against an event-level keyboard model.
module tb_ps2_note_decoder;

  localparam int H = 8;
  localparam logic [6:0] BASE = 7'd60;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   err_seen = 0;
  int   val_seen = 0;

  ps2_note_decoder_if bus ();

  ps2_note_decoder #(
    .BASE_NOTE      (BASE),
    .TIMEOUT_CYCLES (17'd64)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (bus.frame_err) err_seen++;
    if (bus.scan_valid) val_seen++;
  end

  logic [7:0] keys [13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                            8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B,
                            8'h42};
  logic [7:0] unm [5] = '{8'h15, 8'h1A, 8'h22, 8'h4B, 8'h5A};

  int         nv, ne;
  logic [6:0] nt;
  logic [7:0] cd;

  function automatic logic [6:0] note_of(input logic [7:0] c);
    note_of = 7'd0;
    for (int i = 0; i < 13; i++)
      if (keys[i] == c) note_of = BASE + 7'(i);
  endfunction

  // Drives one 11-bit frame; watches the outputs just after the stop edge.
  task automatic send_frame(input logic [7:0] b, input bit flip,
                            output int v, output int e,
                            output logic [6:0] n, output logic [7:0] c);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ flip, b, 1'b0};
    v = 0; e = 0; n = 7'd0; c = 8'd0;
    for (int i = 0; i < 11; i++) begin
      bus.ps2_data = f[i];
      repeat (H) @(negedge clk_in);
      bus.ps2_clk = 1'b0;
      if (i == 10) begin
        for (int k = 0; k < 12; k++) begin
          @(negedge clk_in);
          if (bus.scan_valid) begin
            if (v == 0) begin
              n = bus.keyboard_note;
              c = bus.scan_code;
            end
            v++;
          end
          if (bus.frame_err) e++;
        end
      end else begin
        repeat (H) @(negedge clk_in);
      end
      bus.ps2_clk = 1'b1;
    end
    repeat (H) @(negedge clk_in);
    bus.ps2_data = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = f[i];
      repeat (H) @(negedge clk_in);
      bus.ps2_clk = 1'b0;
      repeat (H) @(negedge clk_in);
      bus.ps2_clk = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    #2 rst_in = 1'b1;
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (4) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic test_reset();
    total++;
    if (bus.keyboard_note !== 7'd0) begin
      bad++;
      $display("FAIL reset_note got=%0d want=0", bus.keyboard_note);
    end
    total++;
    if (bus.scan_code !== 8'd0) begin
      bad++;
      $display("FAIL reset_code got=%h want=00", bus.scan_code);
    end
    total++;
    if (bus.scan_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_pulses got=%b%b want=00",
               bus.scan_valid, bus.frame_err);
    end
  endtask

  task automatic test_single_make();
    send_frame(8'h1C, 1'b0, nv, ne, nt, cd);
    total++;
    if (nv != 1 || ne != 0) begin
      bad++;
      $display("FAIL make_pulse got=v%0d/e%0d want=v1/e0", nv, ne);
    end
    total++;
    if (nt !== 7'd60 || cd !== 8'h1C) begin
      bad++;
      $display("FAIL make_value got=%0d/%h want=60/1c", nt, cd);
    end
  endtask

  task automatic test_last_wins();
    send_frame(8'h42, 1'b0, nv, ne, nt, cd);
    total++;
    if (bus.keyboard_note !== 7'd72) begin
      bad++;
      $display("FAIL last_wins got=%0d want=72", bus.keyboard_note);
    end
    send_frame(8'hF0, 1'b0, nv, ne, nt, cd);
    send_frame(8'h1C, 1'b0, nv, ne, nt, cd);
    total++;
    if (bus.keyboard_note !== 7'd72) begin
      bad++;
      $display("FAIL other_break got=%0d want=72", bus.keyboard_note);
    end
    send_frame(8'hF0, 1'b0, nv, ne, nt, cd);
    send_frame(8'h42, 1'b0, nv, ne, nt, cd);
    total++;
    if (bus.keyboard_note !== 7'd0) begin
      bad++;
      $display("FAIL held_break got=%0d want=0", bus.keyboard_note);
    end
  endtask

  task automatic test_parity_err();
    send_frame(8'h1C, 1'b1, nv, ne, nt, cd);
    total++;
    if (nv != 0 || ne != 1) begin
      bad++;
      $display("FAIL par_pulse got=v%0d/e%0d want=v0/e1", nv, ne);
    end
    total++;
    if (bus.keyboard_note !== 7'd0 || bus.scan_code !== 8'h42) begin
      bad++;
      $display("FAIL par_hold got=%0d/%h want=0/42",
               bus.keyboard_note, bus.scan_code);
    end
    send_frame(8'h23, 1'b0, nv, ne, nt, cd);
    total++;
    if (nt !== 7'd64) begin
      bad++;
      $display("FAIL par_recover got=%0d want=64", nt);
    end
  endtask

  task automatic test_extended();
    send_frame(8'hF0, 1'b0, nv, ne, nt, cd);
    send_frame(8'h23, 1'b0, nv, ne, nt, cd);
    send_frame(8'hE0, 1'b0, nv, ne, nt, cd);
    send_frame(8'h1C, 1'b0, nv, ne, nt, cd);
    total++;
    if (bus.keyboard_note !== 7'd0) begin
      bad++;
      $display("FAIL ext_make got=%0d want=0", bus.keyboard_note);
    end
    send_frame(8'hE0, 1'b0, nv, ne, nt, cd);
    send_frame(8'hF0, 1'b0, nv, ne, nt, cd);
    send_frame(8'h1C, 1'b0, nv, ne, nt, cd);
    total++;
    if (bus.keyboard_note !== 7'd0) begin
      bad++;
      $display("FAIL ext_break got=%0d want=0", bus.keyboard_note);
    end
    send_frame(8'h2B, 1'b0, nv, ne, nt, cd);
    total++;
    if (bus.keyboard_note !== 7'd65) begin
      bad++;
      $display("FAIL ext_after got=%0d want=65", bus.keyboard_note);
    end
  endtask

  task automatic test_timeout();
    int e0, v0;
    e0 = err_seen;
    v0 = val_seen;
    send_bits(8'h55, 5);
    repeat (100) @(negedge clk_in);
    send_frame(8'h3B, 1'b0, nv, ne, nt, cd);
    total++;
    if (err_seen != e0 || val_seen != v0 + 1) begin
      bad++;
      $display("FAIL timeout_pulses got=e%0d/v%0d want=e0/v1",
               err_seen - e0, val_seen - v0);
    end
    total++;
    if (bus.keyboard_note !== 7'd71) begin
      bad++;
      $display("FAIL timeout_note got=%0d want=71", bus.keyboard_note);
    end
  endtask

  task automatic test_async_reset();
    send_frame(8'h1C, 1'b0, nv, ne, nt, cd);
    send_bits(8'h34, 4);
    @(negedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    total++;
    if (bus.keyboard_note !== 7'd0 || bus.scan_code !== 8'd0) begin
      bad++;
      $display("FAIL async_rst got=%0d/%h want=0/00",
               bus.keyboard_note, bus.scan_code);
    end
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    send_frame(8'h34, 1'b0, nv, ne, nt, cd);
    total++;
    if (nv != 1 || nt !== 7'd67) begin
      bad++;
      $display("FAIL post_rst got=v%0d/%0d want=v1/67", nv, nt);
    end
    send_frame(8'hF0, 1'b0, nv, ne, nt, cd);
    do_reset();
    send_frame(8'h1C, 1'b0, nv, ne, nt, cd);
    total++;
    if (bus.keyboard_note !== 7'd60) begin
      bad++;
      $display("FAIL f0_forgot got=%0d want=60", bus.keyboard_note);
    end
  endtask

  task automatic test_random();
    logic [7:0] held, k, last;
    logic [6:0] mnote;
    int ev;
    do_reset();
    held = 8'd0;
    mnote = 7'd0;
    for (int t = 0; t < 40; t++) begin
      ev = int'($urandom_range(5, 0));
      k = keys[$urandom_range(12, 0)];
      last = k;
      case (ev)
        0: begin
          send_frame(k, 1'b0, nv, ne, nt, cd);
          held = k;
          mnote = note_of(k);
        end
        1: begin
          if (held != 8'd0 && $urandom_range(1, 0) == 1) k = held;
          last = k;
          send_frame(8'hF0, 1'b0, nv, ne, nt, cd);
          send_frame(k, 1'b0, nv, ne, nt, cd);
          if (k == held) begin
            held = 8'd0;
            mnote = 7'd0;
          end
        end
        2: begin
          last = unm[$urandom_range(4, 0)];
          send_frame(last, 1'b0, nv, ne, nt, cd);
        end
        3: begin
          send_frame(8'hE0, 1'b0, nv, ne, nt, cd);
          send_frame(k, 1'b0, nv, ne, nt, cd);
        end
        4: begin
          send_frame(8'hE0, 1'b0, nv, ne, nt, cd);
          send_frame(8'hF0, 1'b0, nv, ne, nt, cd);
          send_frame(k, 1'b0, nv, ne, nt, cd);
        end
        default: begin
          send_frame(k, 1'b1, nv, ne, nt, cd);
        end
      endcase
      total++;
      if (bus.keyboard_note !== mnote) begin
        bad++;
        $display("FAIL rnd_note ev=%0d t=%0d got=%0d want=%0d",
                 ev, t, bus.keyboard_note, mnote);
      end
      total++;
      if (ev == 5) begin
        if (nv != 0 || ne != 1) begin
          bad++;
          $display("FAIL rnd_err t=%0d got=v%0d/e%0d want=v0/e1",
                   t, nv, ne);
        end
      end else if (nv != 1 || ne != 0 || cd !== last) begin
        bad++;
        $display("FAIL rnd_code t=%0d got=v%0d/e%0d/%h want=v1/e0/%h",
                 t, nv, ne, cd, last);
      end
    end
  endtask

  initial begin
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (4) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (4) @(negedge clk_in);
    test_reset();
    test_single_make();
    test_last_wins();
    test_parity_err();
    test_extended();
    test_timeout();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
